// File: rtl/comparador_serie_pkg.sv
// Shared types and helpers for the serial magnitude comparator.
package comparador_serie_pkg;

  // FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Result flags, one-hot once a comparison has finished
  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_res_t;

  localparam cmp_res_t RES_NONE = '{lt: 1'b0, eq: 1'b0, gt: 1'b0};
  localparam cmp_res_t RES_LT   = '{lt: 1'b1, eq: 1'b0, gt: 1'b0};
  localparam cmp_res_t RES_EQ   = '{lt: 1'b0, eq: 1'b1, gt: 1'b0};
  localparam cmp_res_t RES_GT   = '{lt: 1'b0, eq: 1'b0, gt: 1'b1};

  // Ceiling log2 with a floor of 1 so a single-chunk counter still has a bit
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < n) begin
      w = w + 1;
    end
    if (w == 0) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/comparador_serie_cmp_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice.
module cmp_chunk #(
  parameter int unsigned CHUNK = 2
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  // Slice relation, exactly one output high
  always_comb begin
    lt = (x < y);
    eq = (x == y);
    gt = (x > y);
  end

endmodule

// File: rtl/comparador_serie.sv
// Sequential MSB-first magnitude comparator, CHUNK bits per clock.
module comparador_serie
  import comparador_serie_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CNT_W  = clog2_min1(NCHUNK);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] sa, sa_n;
  logic [WIDTH-1:0] sb, sb_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  cmp_res_t         res, res_n;
  logic             busy_n, done_n;

  logic chunk_lt, chunk_eq, chunk_gt;

  // Slice comparator on the current most-significant chunk
  cmp_chunk #(.CHUNK(CHUNK)) u_cmp_chunk (
    .x  (sa[WIDTH-1 -: CHUNK]),
    .y  (sb[WIDTH-1 -: CHUNK]),
    .lt (chunk_lt),
    .eq (chunk_eq),
    .gt (chunk_gt)
  );

  // Next-state, datapath and output decode
  always_comb begin
    state_n = state;
    sa_n    = sa;
    sb_n    = sb;
    cnt_n   = cnt;
    res_n   = res;

    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          // Flipping the sign bit maps two's complement order onto unsigned order
          sa_n = a;
          sb_n = b;
          if (signed_mode) begin
            sa_n[WIDTH-1] = ~a[WIDTH-1];
            sb_n[WIDTH-1] = ~b[WIDTH-1];
          end
          cnt_n   = '0;
          res_n   = RES_NONE;
          state_n = ST_COMPARE;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_COMPARE: begin
        if (chunk_lt) begin
          res_n   = RES_LT;
          state_n = ST_DONE;
        end else if (chunk_gt) begin
          res_n   = RES_GT;
          state_n = ST_DONE;
        end else if (chunk_eq && (cnt == CNT_LAST)) begin
          res_n   = RES_EQ;
          state_n = ST_DONE;
        end else begin
          sa_n  = sa << CHUNK;
          sb_n  = sb << CHUNK;
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    busy_n = (state_n == ST_COMPARE);
    done_n = (state_n == ST_DONE);
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      sa    <= '0;
      sb    <= '0;
      cnt   <= '0;
      res   <= RES_NONE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      sa    <= sa_n;
      sb    <= sb_n;
      cnt   <= cnt_n;
      res   <= res_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  assign lt = res.lt;
  assign eq = res.eq;
  assign gt = res.gt;

endmodule

// File: tb/tb_comparador_serie.sv
// Directed self-checking bench for comparador_serie.
`timescale 1ns/1ps
module tb_comparador_serie;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start = 1'b0;
  logic       signed_mode = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       busy, done, lt, eq, gt;

  logic        start2 = 1'b0;
  logic        signed_mode2 = 1'b0;
  logic [15:0] a2 = '0;
  logic [15:0] b2 = '0;
  logic        busy2, done2, lt2, eq2, gt2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  comparador_serie #(.WIDTH(8), .CHUNK(2)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy), .done(done), .lt(lt), .eq(eq), .gt(gt)
  );

  comparador_serie #(.WIDTH(16), .CHUNK(16)) dut_wide (
    .clk(clk), .rst(rst), .start(start2), .signed_mode(signed_mode2),
    .a(a2), .b(b2), .busy(busy2), .done(done2), .lt(lt2), .eq(eq2), .gt(gt2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One accept on the 8-bit unit; operands are scrambled after the accept edge
  task automatic run_cmp(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic sm, input logic [2:0] exp_flags, input int exp_lat,
                         output int nbusy);
    int lat;
    lat = 0;
    nbusy = 0;
    @(posedge clk); #1;
    a = av; b = bv; signed_mode = sm; start = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      a = ~av; b = ~bv; signed_mode = ~sm;
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
      if (busy) nbusy++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_flags"}, 32'({lt, eq, gt}), 32'(exp_flags));
  endtask

  initial begin
    int nb;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", 32'({busy, done, lt, eq, gt}), 32'd0);
    chk("reset_outs_wide", 32'({busy2, done2, lt2, eq2, gt2}), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Equal operands: full scan
    run_cmp("eq_3c", 8'h3C, 8'h3C, 1'b0, 3'b010, 5, nb);
    chk("eq_3c_busy_cycles", 32'(nb), 32'd4);

    // Sign handling on the MSB chunk
    run_cmp("u_80_7f", 8'h80, 8'h7F, 1'b0, 3'b001, 2, nb);
    run_cmp("s_80_7f", 8'h80, 8'h7F, 1'b1, 3'b100, 2, nb);

    // Difference in last chunk, then hold while idle
    run_cmp("u_12_13", 8'h12, 8'h13, 1'b0, 3'b100, 5, nb);
    repeat (3) @(negedge clk);
    chk("hold_idle", 32'({busy, done, lt, eq, gt}), 32'b00100);

    // Signed negative vs negative, differing in chunk 2
    run_cmp("s_f0_c0", 8'hF0, 8'hC0, 1'b1, 3'b001, 3, nb);

    // start held through busy, operands changed mid-op, back-to-back accept
    @(posedge clk); #1;
    a = 8'h3C; b = 8'h3C; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 8'hFF; b = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("b2b_busy_mid", 32'({busy, done}), 32'b10);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_first_done", 32'({done, lt, eq, gt}), 32'b1010);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("b2b_no_gap", 32'({busy, done}), 32'b10);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_second_done", 32'({done, lt, eq, gt}), 32'b1001);
    @(posedge clk);
    @(negedge clk);
    chk("done_one_cycle", 32'({busy, done}), 32'b00);

    // Reset during the second COMPARE cycle
    @(posedge clk); #1;
    a = 8'h3C; b = 8'h3C; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_outs", 32'({busy, done, lt, eq, gt}), 32'd0);
    repeat (4) @(negedge clk);
    chk("abort_no_done", 32'({busy, done}), 32'd0);
    run_cmp("u_01_00", 8'h01, 8'h00, 1'b0, 3'b001, 5, nb);

    // Single-chunk 16-bit instance
    @(posedge clk); #1;
    a2 = 16'hFFFF; b2 = 16'h0001; signed_mode2 = 1'b1; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    @(negedge clk);
    chk("wide_s_busy", 32'({busy2, done2}), 32'b10);
    @(posedge clk);
    @(negedge clk);
    chk("wide_s_done", 32'({done2, lt2, eq2, gt2}), 32'b1100);
    @(posedge clk); #1;
    signed_mode2 = 1'b0; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("wide_u_done", 32'({done2, lt2, eq2, gt2}), 32'b1001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
